// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and common-data-bus source codes for the CDB arbiter slice.
package cdb_arbiter_pkg;

    localparam int ENTRY_W_DEF = 3;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 32;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_ALU  = 2'b01,
        SRC_LSM  = 2'b10,
        SRC_BRA  = 2'b11
    } cdb_src_e;

    typedef enum logic [1:0] {
        PTR_ALU = 2'b00,
        PTR_LSM = 2'b01,
        PTR_BRA = 2'b10
    } rr_ptr_e;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter; the pointer names the highest-priority source.
//   state   | meaning
//   PTR_ALU | order ALU, LSM, BRA
//   PTR_LSM | order LSM, BRA, ALU
//   PTR_BRA | order BRA, ALU, LSM
module rr_arbiter3
    import cdb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic [2:0] req,
    output logic [2:0] grant
);

    rr_ptr_e ptr, ptr_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) ptr <= PTR_ALU;
        else        ptr <= ptr_nxt;
    end

    always_comb begin
        grant   = 3'b000;
        ptr_nxt = ptr;
        // Reset and flush both suppress every grant, so the pointer holds.
        if (rst_n && !flush) begin
            case (ptr)
                PTR_LSM: begin
                    if      (req[1]) grant = 3'b010;
                    else if (req[2]) grant = 3'b100;
                    else if (req[0]) grant = 3'b001;
                end
                PTR_BRA: begin
                    if      (req[2]) grant = 3'b100;
                    else if (req[0]) grant = 3'b001;
                    else if (req[1]) grant = 3'b010;
                end
                default: begin
                    if      (req[0]) grant = 3'b001;
                    else if (req[1]) grant = 3'b010;
                    else if (req[2]) grant = 3'b100;
                end
            endcase
        end
        if      (grant[0]) ptr_nxt = PTR_LSM;
        else if (grant[1]) ptr_nxt = PTR_BRA;
        else if (grant[2]) ptr_nxt = PTR_ALU;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one of ALU/LSM/BRA per cycle and broadcasts it one cycle later.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ENTRY_W = ENTRY_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_req,
    input  logic [ENTRY_W-1:0] alu_entry,
    input  logic [DATA_W-1:0]  alu_value,
    output logic               alu_ack,
    input  logic               lsm_req,
    input  logic [ENTRY_W-1:0] lsm_entry,
    input  logic [DATA_W-1:0]  lsm_value,
    input  logic [ADDR_W-1:0]  lsm_addr,
    output logic               lsm_ack,
    input  logic               bra_req,
    input  logic [ENTRY_W-1:0] bra_entry,
    input  logic [1:0]         bra_value,
    output logic               bra_ack,
    input  logic               flush,
    output logic               cdb_valid,
    output logic [1:0]         cdb_src,
    output logic [ENTRY_W-1:0] cdb_entry,
    output logic [DATA_W-1:0]  cdb_value,
    output logic [ADDR_W-1:0]  cdb_addr
);

    logic [2:0] grant;

    rr_arbiter3 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .req   ({bra_req, lsm_req, alu_req}),
        .grant (grant)
    );

    assign alu_ack = grant[0];
    assign lsm_ack = grant[1];
    assign bra_ack = grant[2];

    // Payload is captured only in the ack cycle; an idle cycle clears the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_src   <= SRC_NONE;
            cdb_entry <= '0;
            cdb_value <= '0;
            cdb_addr  <= '0;
        end else if (grant[0]) begin
            cdb_valid <= 1'b1;
            cdb_src   <= SRC_ALU;
            cdb_entry <= alu_entry;
            cdb_value <= alu_value;
            cdb_addr  <= '0;
        end else if (grant[1]) begin
            cdb_valid <= 1'b1;
            cdb_src   <= SRC_LSM;
            cdb_entry <= lsm_entry;
            cdb_value <= lsm_value;
            cdb_addr  <= lsm_addr;
        end else if (grant[2]) begin
            cdb_valid <= 1'b1;
            cdb_src   <= SRC_BRA;
            cdb_entry <= bra_entry;
            cdb_value <= {{(DATA_W-2){1'b0}}, bra_value};
            cdb_addr  <= '0;
        end else begin
            cdb_valid <= 1'b0;
            cdb_src   <= SRC_NONE;
            cdb_entry <= '0;
            cdb_value <= '0;
            cdb_addr  <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single sources, round-robin, flush and mid-run reset.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_req, lsm_req, bra_req, flush;
    logic [2:0]  alu_entry, lsm_entry, bra_entry;
    logic [31:0] alu_value, lsm_value, lsm_addr;
    logic [1:0]  bra_value;
    logic        alu_ack, lsm_ack, bra_ack;
    logic        cdb_valid;
    logic [1:0]  cdb_src;
    logic [2:0]  cdb_entry;
    logic [31:0] cdb_value, cdb_addr;

    int vec_count  = 0;
    int miss_count = 0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_req   (alu_req),
        .alu_entry (alu_entry),
        .alu_value (alu_value),
        .alu_ack   (alu_ack),
        .lsm_req   (lsm_req),
        .lsm_entry (lsm_entry),
        .lsm_value (lsm_value),
        .lsm_addr  (lsm_addr),
        .lsm_ack   (lsm_ack),
        .bra_req   (bra_req),
        .bra_entry (bra_entry),
        .bra_value (bra_value),
        .bra_ack   (bra_ack),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_src   (cdb_src),
        .cdb_entry (cdb_entry),
        .cdb_value (cdb_value),
        .cdb_addr  (cdb_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        alu_req = 1'b0; lsm_req = 1'b0; bra_req = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_req = 1'b1; lsm_req = 1'b1; bra_req = 1'b1; flush = 1'b0;
        alu_entry = 3'd1; alu_value = 32'hDEAD_BEEF;
        lsm_entry = 3'd2; lsm_value = 32'hCAFE_0000; lsm_addr = 32'h0000_4000;
        bra_entry = 3'd3; bra_value = 2'b11;
        tick();
        #1;
        vec_count++;
        if ({alu_ack, lsm_ack, bra_ack} !== 3'b000) begin
            miss_count++;
            $display("FAIL reset_acks: got %b want 000", {alu_ack, lsm_ack, bra_ack});
        end
        tick();
        vec_count++;
        if ({cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_addr} !== '0) begin
            miss_count++;
            $display("FAIL reset_outputs: valid=%b src=%b entry=%0d value=%h addr=%h want all zero",
                     cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_addr);
        end
        clear_reqs();
        rst_n = 1'b1;
        tick();
    endtask

    // Pointer starts at ALU after reset.
    task automatic test_alu_single();
        alu_req = 1'b1; alu_entry = 3'd3; alu_value = 32'h0000_00AA;
        #1;
        vec_count++;
        if ({alu_ack, lsm_ack, bra_ack} !== 3'b100) begin
            miss_count++;
            $display("FAIL alu_ack: got %b want 100", {alu_ack, lsm_ack, bra_ack});
        end
        tick();
        alu_req = 1'b0;
        vec_count++;
        if ({cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_addr} !== {1'b1, 2'b01, 3'd3, 32'hAA, 32'h0}) begin
            miss_count++;
            $display("FAIL alu_bcast: valid=%b src=%b entry=%0d value=%h addr=%h want 1 01 3 000000aa 0",
                     cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_addr);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ack [4];
        logic [1:0] exp_src [4];
        logic [2:0] exp_ent [4];
        exp_ack = '{3'b100, 3'b010, 3'b001, 3'b100};
        exp_src = '{2'b01, 2'b10, 2'b11, 2'b01};
        exp_ent = '{3'd1, 3'd4, 3'd6, 3'd1};
        rst_n = 1'b0;
        alu_req = 1'b1; alu_entry = 3'd1; alu_value = 32'h11;
        lsm_req = 1'b1; lsm_entry = 3'd4; lsm_value = 32'h44; lsm_addr = 32'h400;
        bra_req = 1'b1; bra_entry = 3'd6; bra_value = 2'b01;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vec_count++;
            if ({alu_ack, lsm_ack, bra_ack} !== exp_ack[i]) begin
                miss_count++;
                $display("FAIL rr_ack[%0d]: got %b want %b", i, {alu_ack, lsm_ack, bra_ack}, exp_ack[i]);
            end
            tick();
            vec_count++;
            if ({cdb_valid, cdb_src, cdb_entry} !== {1'b1, exp_src[i], exp_ent[i]}) begin
                miss_count++;
                $display("FAIL rr_bcast[%0d]: valid=%b src=%b entry=%0d want 1 %b %0d",
                         i, cdb_valid, cdb_src, cdb_entry, exp_src[i], exp_ent[i]);
            end
        end
        clear_reqs();
    endtask

    task automatic test_lsm_and_idle();
        lsm_req = 1'b1; lsm_entry = 3'd5; lsm_value = 32'h1234; lsm_addr = 32'h0000_1008;
        #1;
        vec_count++;
        if ({alu_ack, lsm_ack, bra_ack} !== 3'b010) begin
            miss_count++;
            $display("FAIL lsm_ack: got %b want 010", {alu_ack, lsm_ack, bra_ack});
        end
        tick();
        lsm_req = 1'b0;
        vec_count++;
        if ({cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_addr} !== {1'b1, 2'b10, 3'd5, 32'h1234, 32'h1008}) begin
            miss_count++;
            $display("FAIL lsm_bcast: valid=%b src=%b entry=%0d value=%h addr=%h want 1 10 5 00001234 00001008",
                     cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_addr);
        end
        tick();
        vec_count++;
        if ({cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_addr} !== '0) begin
            miss_count++;
            $display("FAIL idle_bcast: valid=%b src=%b entry=%0d value=%h addr=%h want all zero",
                     cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_addr);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            alu_req = 1'b1; alu_entry = 3'(i + 2); alu_value = 32'h100 + 32'(i);
            #1;
            vec_count++;
            if (alu_ack !== 1'b1) begin
                miss_count++;
                $display("FAIL b2b_ack[%0d]: got %b want 1", i, alu_ack);
            end
            tick();
            vec_count++;
            if ({cdb_valid, cdb_src, cdb_entry, cdb_value} !== {1'b1, 2'b01, 3'(i + 2), 32'h100 + 32'(i)}) begin
                miss_count++;
                $display("FAIL b2b_bcast[%0d]: valid=%b src=%b entry=%0d value=%h want 1 01 %0d %h",
                         i, cdb_valid, cdb_src, cdb_entry, cdb_value, i + 2, 32'h100 + 32'(i));
            end
        end
        clear_reqs();
    endtask

    task automatic test_flush();
        alu_req = 1'b1; alu_entry = 3'd7; alu_value = 32'h55;
        #1;
        vec_count++;
        if ({alu_ack, lsm_ack, bra_ack} !== 3'b100) begin
            miss_count++;
            $display("FAIL flush_pre_ack: got %b want 100", {alu_ack, lsm_ack, bra_ack});
        end
        tick();
        lsm_req = 1'b1; bra_req = 1'b1; bra_entry = 3'd2; bra_value = 2'b10; flush = 1'b1;
        #1;
        vec_count++;
        if ({alu_ack, lsm_ack, bra_ack} !== 3'b000) begin
            miss_count++;
            $display("FAIL flush_ack: got %b want 000", {alu_ack, lsm_ack, bra_ack});
        end
        vec_count++;
        if ({cdb_valid, cdb_src, cdb_value} !== {1'b1, 2'b01, 32'h55}) begin
            miss_count++;
            $display("FAIL flush_prev_bcast: valid=%b src=%b value=%h want 1 01 00000055",
                     cdb_valid, cdb_src, cdb_value);
        end
        tick();
        vec_count++;
        if ({cdb_valid, cdb_src} !== 3'b000) begin
            miss_count++;
            $display("FAIL flush_bcast: valid=%b src=%b want 0 00", cdb_valid, cdb_src);
        end
        flush = 1'b0;
        #1;
        vec_count++;
        if ({alu_ack, lsm_ack, bra_ack} !== 3'b010) begin
            miss_count++;
            $display("FAIL flush_ptr_hold: got %b want 010", {alu_ack, lsm_ack, bra_ack});
        end
        tick();
        lsm_req = 1'b0;
        #1;
        vec_count++;
        if ({alu_ack, lsm_ack, bra_ack} !== 3'b001) begin
            miss_count++;
            $display("FAIL bra_ack: got %b want 001", {alu_ack, lsm_ack, bra_ack});
        end
        tick();
        vec_count++;
        if ({cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_addr} !== {1'b1, 2'b11, 3'd2, 32'h2, 32'h0}) begin
            miss_count++;
            $display("FAIL bra_bcast: valid=%b src=%b entry=%0d value=%h addr=%h want 1 11 2 00000002 0",
                     cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_addr);
        end
        clear_reqs();
    endtask

    task automatic test_reset_mid();
        lsm_req = 1'b1; lsm_entry = 3'd5; lsm_value = 32'h77; lsm_addr = 32'h10;
        tick();
        rst_n = 1'b0;
        #1;
        vec_count++;
        if ({alu_ack, lsm_ack, bra_ack} !== 3'b000) begin
            miss_count++;
            $display("FAIL midrst_ack: got %b want 000", {alu_ack, lsm_ack, bra_ack});
        end
        tick();
        vec_count++;
        if ({cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_addr} !== '0) begin
            miss_count++;
            $display("FAIL midrst_outputs: valid=%b src=%b entry=%0d value=%h addr=%h want all zero",
                     cdb_valid, cdb_src, cdb_entry, cdb_value, cdb_addr);
        end
        rst_n = 1'b1; lsm_req = 1'b0; alu_req = 1'b1; bra_req = 1'b1;
        alu_entry = 3'd4; alu_value = 32'h99;
        #1;
        vec_count++;
        if ({alu_ack, lsm_ack, bra_ack} !== 3'b100) begin
            miss_count++;
            $display("FAIL midrst_ptr: got %b want 100", {alu_ack, lsm_ack, bra_ack});
        end
        tick();
        vec_count++;
        if ({cdb_valid, cdb_src, cdb_entry, cdb_value} !== {1'b1, 2'b01, 3'd4, 32'h99}) begin
            miss_count++;
            $display("FAIL midrst_bcast: valid=%b src=%b entry=%0d value=%h want 1 01 4 00000099",
                     cdb_valid, cdb_src, cdb_entry, cdb_value);
        end
        clear_reqs();
    endtask

    initial begin
        clear_reqs();
        rst_n = 1'b0;
        alu_entry = '0; alu_value = '0;
        lsm_entry = '0; lsm_value = '0; lsm_addr = '0;
        bra_entry = '0; bra_value = '0;
        test_reset();
        test_alu_single();
        test_round_robin();
        test_lsm_and_idle();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter ENTRY_W, default `ROB_Entry_Width (3): ROB entry tag width.
REQ-002 Parameter DATA_W, default `Data_Width (32): result value width.
REQ-003 Parameter ADDR_W, default `Addr_Width (32): store address width.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 alu_req  in  1  ALU result pending; alu_entry in ENTRY_W; alu_value in DATA_W.
REQ-007 alu_ack  out  1  ALU result accepted this cycle.
REQ-008 lsm_req  in  1  load/store result pending; lsm_entry in ENTRY_W; lsm_value in DATA_W; lsm_addr in ADDR_W.
REQ-009 lsm_ack  out  1  LSM result accepted this cycle.
REQ-010 bra_req  in  1  branch outcome pending; bra_entry in ENTRY_W; bra_value in 2 (ROB branch code).
REQ-011 bra_ack  out  1  branch outcome accepted this cycle.
REQ-012 flush  in  1  ROB mispredict recovery (ROB pc_modify).
REQ-013 cdb_valid  out  1  broadcast valid to ROB and reservation stations.
REQ-014 cdb_src  out  2  source: 00 none, 01 ALU, 10 LSM, 11 BRA.
REQ-015 cdb_entry  out  ENTRY_W; cdb_value  out  DATA_W; cdb_addr  out  ADDR_W.

Function
REQ-016 At most one requester SHALL be acked per cycle; ack is combinational from req, flush and priority pointer.
REQ-017 An ack SHALL be asserted only when the matching req is high and flush is low.
REQ-018 Requesters hold req and payload stable until acked; the block SHALL sample payload in the ack cycle only.
REQ-019 Priority SHALL be round-robin over order ALU, LSM, BRA, starting at the pointer source.
REQ-020 After acking source i, the pointer SHALL move to the source following i (BRA wraps to ALU); with no ack it SHALL hold.
REQ-021 A continuously requesting source SHALL be acked within 3 cycles of raising req (flush-free).
REQ-022 A lone requester SHALL be acked every cycle (back-to-back).
REQ-023 Broadcast latency SHALL be exactly 1 cycle: acked payload appears on cdb_* registers the next cycle, cdb_valid=1, cdb_src=source.
REQ-024 In a cycle with no ack, next-cycle cdb_valid SHALL be 0, cdb_src 00, payload all zero.
REQ-025 ALU grant: cdb_addr SHALL be 0; BRA grant: cdb_value SHALL be bra_value zero-extended, cdb_addr 0.
REQ-026 Flush high: no ack that cycle, next-cycle cdb_valid 0, pointer unchanged; a broadcast registered the previous cycle SHALL still complete.
REQ-027 Flush and req on the same cycle: the requester is not acked and SHALL retain its req next cycle if still valid.

Reset
REQ-028 rst_n low at a posedge SHALL set pointer to ALU, cdb_valid 0, cdb_src 00, cdb_entry/value/addr 0.
REQ-029 While rst_n low, all acks SHALL be 0; reset mid-operation discards any pending arbitration without broadcast.

Structure
REQ-030 Widths and cdb_src codes (SRC_NONE/ALU/LSM/BRA) SHALL live in the shared defines.v.
REQ-031 Priority logic SHALL be a sub-module rr_arbiter3 (3 req in, one-hot grant out, pointer state inside).
REQ-032 Output stage SHALL be a single register bank; no payload buffering beyond it.

Verification
REQ-033 ALU only, entry 3, value 0x0000_00AA -> alu_ack same cycle; next cycle cdb_valid 1, src 01, entry 3, value 0xAA, addr 0.
REQ-034 ALU, LSM, BRA all held high from reset -> acks ALU, LSM, BRA, ALU on cycles 0-3; broadcasts follow by one cycle.
REQ-035 LSM entry 5, value 0x1234, addr 0x0000_1008 -> next cycle src 10, entry 5, value 0x1234, addr 0x1008.
REQ-036 BRA entry 2, value 2'b10, flush high same cycle -> no ack, cdb_valid 0 next; flush low -> bra_ack, src 11, value 0x2.
REQ-037 rst_n low during LSM request with pointer at BRA -> no ack, outputs zero; after release, ALU+BRA requesting -> ALU acked first.
